// File: rtl/proc_control_fsm_pkg.sv
// Shared definitions for the processor instruction control unit: widths,
// opcode and ALU codes, function-word field positions and the state type.
// Build option: PROC_CTRL_LOGIC_OPS_EN turns opcodes 100/101 into and/xor.
package proc_control_fsm_pkg;

    localparam int FUNC_W = 10;
    localparam int NREG   = 8;

    // Function-word field positions: III XXX YYY -
    localparam int OP_HI = 9;
    localparam int OP_LO = 7;
    localparam int X_HI  = 6;
    localparam int X_LO  = 4;
    localparam int Y_HI  = 3;
    localparam int Y_LO  = 1;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_XOR = 2'b11;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    // True for opcodes that take the three-step A/G path through the ALU.
    function automatic logic is_alu_op(input logic [2:0] op);
        logic alu;
        alu = (op == OP_ADD) || (op == OP_SUB);
`ifdef PROC_CTRL_LOGIC_OPS_EN
        alu = alu || (op == OP_AND) || (op == OP_XOR);
`endif
        return alu;
    endfunction

    // ALU operation selected by an ALU-class opcode.
    function automatic logic [1:0] alu_code(input logic [2:0] op);
        logic [1:0] code;
        code = ALU_ADD;
        case (op)
            OP_SUB:  code = ALU_SUB;
            OP_AND:  code = ALU_AND;
            OP_XOR:  code = ALU_XOR;
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/proc_control_fsm_if.sv
// Handshake and control bundle between the function-word source, the
// control unit and the datapath. ctrl is the control unit's view.
interface proc_control_fsm_if;
    import proc_control_fsm_pkg::*;

    logic              run;
    logic [FUNC_W-1:0] func;
    logic              ir_in;
    logic [NREG-1:0]   r_in;
    logic [NREG-1:0]   r_out;
    logic              din_out;
    logic              a_in;
    logic              g_in;
    logic              g_out;
    logic [1:0]        alu_op;
    logic              busy;
    logic              done;

    modport ctrl (
        input  run, func,
        output ir_in, r_in, r_out, din_out, a_in, g_in, g_out, alu_op, busy, done
    );

    modport master (
        output run, func,
        input  ir_in, r_in, r_out, din_out, a_in, g_in, g_out, alu_op, busy, done
    );

endinterface

// File: rtl/proc_control_fsm_dec3to8.sv
// 3-to-8 one-hot decoder with enable; drives register enable vectors.
module proc_control_fsm_dec3to8 (
    input  logic       en,
    input  logic [2:0] sel,
    output logic [7:0] onehot
);

    for (genvar gi = 0; gi < 8; gi++) begin : g_bit
        // Each output line is high only when enabled and selected.
        assign onehot[gi] = en && (sel == 3'(gi));
    end

endmodule

// File: rtl/proc_control_fsm.sv
// Instruction control unit: latches the function word on run, then steps
// T0..T3 issuing register, bus and ALU controls for mv/mvi/add/sub
// (and/xor when PROC_CTRL_LOGIC_OPS_EN is defined) and pulses done.
module proc_control_fsm
    import proc_control_fsm_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    proc_control_fsm_if.ctrl bus
);

    state_t            state_reg;
    state_t            state_next;
    logic [FUNC_W-1:0] ir_reg;

    logic [2:0] op;
    logic [2:0] x;
    logic [2:0] y;
    logic       unused_ir_lsb;

    logic       rin_en;
    logic [2:0] rin_sel;
    logic       rout_en;
    logic [2:0] rout_sel;

    assign op = ir_reg[OP_HI:OP_LO];
    assign x  = ir_reg[X_HI:X_LO];
    assign y  = ir_reg[Y_HI:Y_LO];
    // Bit 0 of the function word carries no meaning for this unit.
    assign unused_ir_lsb = ir_reg[0];

    // State and IR registers; IR only loads when a run is accepted in T0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= T0;
            ir_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == T0 && bus.run) begin
                ir_reg <= bus.func;
            end
        end
    end

    // Next state and Moore controls from state and IR.
    always_comb begin
        state_next  = state_reg;
        rin_en      = 1'b0;
        rin_sel     = x;
        rout_en     = 1'b0;
        rout_sel    = y;
        bus.din_out = 1'b0;
        bus.a_in    = 1'b0;
        bus.g_in    = 1'b0;
        bus.g_out   = 1'b0;
        bus.alu_op  = ALU_ADD;
        bus.done    = 1'b0;
        case (state_reg)
            T0: begin
                if (bus.run) begin
                    state_next = T1;
                end
            end
            T1: begin
                if (op == OP_MV) begin
                    rout_en    = 1'b1;
                    rout_sel   = y;
                    rin_en     = 1'b1;
                    bus.done   = 1'b1;
                    state_next = T0;
                end else if (op == OP_MVI) begin
                    bus.din_out = 1'b1;
                    rin_en      = 1'b1;
                    bus.done    = 1'b1;
                    state_next  = T0;
                end else if (is_alu_op(op)) begin
                    rout_en    = 1'b1;
                    rout_sel   = x;
                    bus.a_in   = 1'b1;
                    state_next = T2;
                end else begin
                    // Unknown opcode: retire immediately without side effects.
                    bus.done   = 1'b1;
                    state_next = T0;
                end
            end
            T2: begin
                rout_en    = 1'b1;
                rout_sel   = y;
                bus.g_in   = 1'b1;
                bus.alu_op = alu_code(op);
                state_next = T3;
            end
            T3: begin
                bus.g_out  = 1'b1;
                rin_en     = 1'b1;
                bus.done   = 1'b1;
                state_next = T0;
            end
            default: state_next = T0;
        endcase
    end

    // IR strobe follows run in T0 but is held off while reset is asserted.
    assign bus.ir_in = rst_n && (state_reg == T0) && bus.run;
    assign bus.busy  = (state_reg != T0);

    proc_control_fsm_dec3to8 u_rin_dec (
        .en     (rin_en),
        .sel    (rin_sel),
        .onehot (bus.r_in)
    );

    proc_control_fsm_dec3to8 u_rout_dec (
        .en     (rout_en),
        .sel    (rout_sel),
        .onehot (bus.r_out)
    );

endmodule
